instruction_fetch_stage: RTL and testbench

Fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. Owns the program counter and issues in-order word fetches to a variable-latency instruction memory over a valid/ready request channel. Buffers returned words with their PC+4 and presents them to IF/ID, honouring the hazard-unit stall and discarding wrong-path fetches on branch/jump redirect.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instruction_fetch_stage.sv | 116 +++++++++++
 tb/tb_instruction_fetch_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the MIPS instruction fetch stage:
// reset PC, NOP encoding, PC step and the instruction buffer entry layout.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
   localparam logic [31:0] PC_INCR          = 32'd4;
   localparam int          ENTRY_W          = 64;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
   } buf_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/clear, occupancy count and empty/full flags.
// DEPTH must be a power of two so the read/write pointers wrap naturally.
module fetch_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; the count gates every
   // read, so stale contents are never observable and the RAM stays reset-free.
   always_ff @(posedge clk_i) begin
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule : fetch_fifo

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: owns the PC, issues credit-limited in-order fetches, buffers
// returned words with PC+4 for IF/ID, and drops wrong-path words after redirect.
module instruction_fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        StallIF,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   output logic        IMemReqValid,
   output logic [31:0] IMemReqAddr,
   input  logic        IMemReqReady,
   input  logic        IMemRespValid,
   input  logic [31:0] IMemRespData,
   output logic        FetchValid,
   output logic [31:0] InstructionOut,
   output logic [31:0] PCResultOut
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int SUM_W = CNT_W + 2;

   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] disc_q, disc_d;

   logic [CNT_W-1:0] pend_count, buf_count;
   logic             pend_empty, pend_full, buf_empty, buf_full;
   logic [31:0]      pend_head;
   buf_entry_t       buf_head, buf_push_data;
   logic [SUM_W-1:0] in_use;

   logic accept, resp_drop, resp_keep, consume;
   logic pend_push, buf_push;

   // Every credit is an unreturned request, a buffered word or a word still to be dropped,
   // so the buffer always has room for whatever is in flight.
   assign in_use       = SUM_W'(pend_count) + SUM_W'(buf_count) + SUM_W'(disc_q);
   assign IMemReqValid = Reset & (in_use < SUM_W'(DEPTH));
   assign IMemReqAddr  = pc_q;
   assign accept       = IMemReqValid & IMemReqReady;

   assign resp_drop = IMemRespValid & (disc_q != '0);
   assign resp_keep = IMemRespValid & (disc_q == '0) & ~pend_empty;

   assign FetchValid = ~buf_empty;
   assign consume    = FetchValid & ~StallIF;

   assign pend_push     = accept & ~pend_full;
   assign buf_push      = resp_keep & (~buf_full | consume);
   assign buf_push_data = '{instr: IMemRespData, pc_plus4: pend_head + PC_INCR};

   assign InstructionOut = FetchValid ? buf_head.instr    : INSTR_NOP;
   assign PCResultOut    = FetchValid ? buf_head.pc_plus4 : 32'h0;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      pc_d   = pc_q;
      disc_d = disc_q;
      if (BranchTaken) begin
         pc_d   = BranchTarget;
         // Everything still in flight becomes wrong-path; a word returning now is already dropped.
         disc_d = disc_q + pend_count + CNT_W'(accept) - CNT_W'(resp_drop | resp_keep);
      end else begin
         if (accept)    pc_d   = pc_q + PC_INCR;
         if (resp_drop) disc_d = disc_q - CNT_W'(1);
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         pc_q   <= RESET_PC;
         disc_q <= '0;
      end else begin
         pc_q   <= pc_d;
         disc_q <= disc_d;
      end
   end

   fetch_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_pending (
      .clk_i       (Clock),
      .rst_ni      (Reset),
      .push_i      (pend_push),
      .push_data_i (pc_q),
      .pop_i       (resp_keep),
      .clear_i     (BranchTaken),
      .head_o      (pend_head),
      .count_o     (pend_count),
      .empty_o     (pend_empty),
      .full_o      (pend_full)
   );

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_ibuf (
      .clk_i       (Clock),
      .rst_ni      (Reset),
      .push_i      (buf_push),
      .push_data_i (buf_push_data),
      .pop_i       (consume),
      .clear_i     (BranchTaken),
      .head_o      (buf_head),
      .count_o     (buf_count),
      .empty_o     (buf_empty),
      .full_o      (buf_full)
   );

endmodule : instruction_fetch_stage

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage (DEPTH 2) with a simple in-order
// memory model; expected values are hand-traced cycle by cycle.
module tb_instruction_fetch_stage;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        StallIF, BranchTaken, IMemReqReady, IMemRespValid;
   logic [31:0] BranchTarget, IMemRespData;
   logic        IMemReqValid, FetchValid;
   logic [31:0] IMemReqAddr, InstructionOut, PCResultOut;

   int          errors = 0;
   int          checks = 0;
   bit          mem_auto;
   logic [31:0] mem_q [$];

   instruction_fetch_stage #(.RESET_PC(32'h0), .DEPTH(2)) dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .StallIF        (StallIF),
      .BranchTaken    (BranchTaken),
      .BranchTarget   (BranchTarget),
      .IMemReqValid   (IMemReqValid),
      .IMemReqAddr    (IMemReqAddr),
      .IMemReqReady   (IMemReqReady),
      .IMemRespValid  (IMemRespValid),
      .IMemRespData   (IMemRespData),
      .FetchValid     (FetchValid),
      .InstructionOut (InstructionOut),
      .PCResultOut    (PCResultOut)
   );

   always #5 Clock = ~Clock;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   // One clock cycle: auto memory answers the oldest accepted address, this cycle's
   // accept is recorded, then outputs settle 1 time unit after the edge.
   task automatic tick();
      if (mem_auto) begin
         if (mem_q.size() > 0) begin
            IMemRespValid = 1'b1;
            IMemRespData  = instr_of(mem_q.pop_front());
         end else begin
            IMemRespValid = 1'b0;
            IMemRespData  = 32'h0;
         end
      end
      if (IMemReqValid && IMemReqReady) mem_q.push_back(IMemReqAddr);
      @(posedge Clock); #1;
      BranchTaken   = 1'b0;
      IMemRespValid = 1'b0;
   endtask

   task automatic do_reset();
      Reset = 1'b0; StallIF = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
      IMemReqReady = 1'b1; IMemRespValid = 1'b0; IMemRespData = 32'h0;
      mem_auto = 1'b1; mem_q.delete();
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      Reset = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b0; StallIF = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
      IMemReqReady = 1'b1; IMemRespValid = 1'b0; IMemRespData = 32'h0;
      mem_auto = 1'b1; mem_q.delete();
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      if (IMemReqValid !== 1'b0) begin errors++; $display("FAIL rst_reqvalid: got %b want 0", IMemReqValid); end
      checks++;
      if (FetchValid !== 1'b0) begin errors++; $display("FAIL rst_fetchvalid: got %b want 0", FetchValid); end
      checks++;
      if (InstructionOut !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", InstructionOut); end
      checks++;
      if (PCResultOut !== 32'h0) begin errors++; $display("FAIL rst_pcresult: got %h want 0", PCResultOut); end
      checks++;
      Reset = 1'b1;
      #1;
      if (IMemReqValid !== 1'b1 || IMemReqAddr !== 32'h0) begin
         errors++; $display("FAIL rst_first_req: got v=%b a=%h want v=1 a=0", IMemReqValid, IMemReqAddr);
      end
      checks++;
   endtask

   task automatic test_basic();
      do_reset();
      tick(); // C1
      if (FetchValid !== 1'b0 || IMemReqAddr !== 32'h4) begin
         errors++; $display("FAIL basic_c1: got fv=%b a=%h want fv=0 a=4", FetchValid, IMemReqAddr);
      end
      checks++;
      tick(); // C2
      if (FetchValid !== 1'b1 || PCResultOut !== 32'h4 || InstructionOut !== 32'hC0DE_0000) begin
         errors++; $display("FAIL basic_c2: got fv=%b pc4=%h i=%h want 1/4/c0de0000", FetchValid, PCResultOut, InstructionOut);
      end
      checks++;
      tick(); // C3
      if (PCResultOut !== 32'h8 || IMemReqValid !== 1'b1 || IMemReqAddr !== 32'h8) begin
         errors++; $display("FAIL basic_c3: got pc4=%h v=%b a=%h want 8/1/8", PCResultOut, IMemReqValid, IMemReqAddr);
      end
      checks++;
      tick(); // C4
      if (FetchValid !== 1'b0 || PCResultOut !== 32'h0 || InstructionOut !== 32'h0) begin
         errors++; $display("FAIL basic_c4: got fv=%b pc4=%h i=%h want 0/0/0", FetchValid, PCResultOut, InstructionOut);
      end
      checks++;
      tick(); // C5
      if (FetchValid !== 1'b1 || PCResultOut !== 32'hC) begin
         errors++; $display("FAIL basic_c5: got fv=%b pc4=%h want 1/c", FetchValid, PCResultOut);
      end
      checks++;
   endtask

   task automatic test_stall();
      do_reset();
      StallIF = 1'b1;
      tick(); tick(); tick(); // C3: buffer full
      for (int c = 3; c <= 5; c++) begin
         if (IMemReqValid !== 1'b0 || FetchValid !== 1'b1 || PCResultOut !== 32'h4 || InstructionOut !== 32'hC0DE_0000) begin
            errors++; $display("FAIL stall_hold_c%0d: got v=%b fv=%b pc4=%h i=%h want 0/1/4/c0de0000",
                               c, IMemReqValid, FetchValid, PCResultOut, InstructionOut);
         end
         checks++;
         tick();
      end
      // C6
      if (PCResultOut !== 32'h4 || IMemReqValid !== 1'b0) begin
         errors++; $display("FAIL stall_c6: got pc4=%h v=%b want 4/0", PCResultOut, IMemReqValid);
      end
      checks++;
      StallIF = 1'b0;
      tick(); // C7
      if (FetchValid !== 1'b1 || PCResultOut !== 32'h8 || InstructionOut !== 32'hC0DE_0004 || IMemReqAddr !== 32'h8) begin
         errors++; $display("FAIL stall_c7: got fv=%b pc4=%h i=%h a=%h want 1/8/c0de0004/8", FetchValid, PCResultOut, InstructionOut, IMemReqAddr);
      end
      checks++;
      tick(); // C8
      if (FetchValid !== 1'b0) begin errors++; $display("FAIL stall_c8: got fv=%b want 0", FetchValid); end
      checks++;
      tick(); // C9
      if (FetchValid !== 1'b1 || PCResultOut !== 32'hC) begin
         errors++; $display("FAIL stall_c9: got fv=%b pc4=%h want 1/c", FetchValid, PCResultOut);
      end
      checks++;
   endtask

   task automatic test_branch();
      do_reset();
      mem_auto = 1'b0;
      tick(); tick(); // C2: two in flight
      BranchTaken = 1'b1; BranchTarget = 32'h100;
      tick(); // C3
      if (IMemReqValid !== 1'b0 || FetchValid !== 1'b0) begin
         errors++; $display("FAIL br_c3: got v=%b fv=%b want 0/0", IMemReqValid, FetchValid);
      end
      checks++;
      IMemRespValid = 1'b1; IMemRespData = instr_of(mem_q.pop_front());
      tick(); // C4
      if (IMemReqValid !== 1'b1 || IMemReqAddr !== 32'h100 || FetchValid !== 1'b0) begin
         errors++; $display("FAIL br_c4: got v=%b a=%h fv=%b want 1/100/0", IMemReqValid, IMemReqAddr, FetchValid);
      end
      checks++;
      IMemRespValid = 1'b1; IMemRespData = instr_of(mem_q.pop_front());
      tick(); // C5
      if (FetchValid !== 1'b0 || IMemReqValid !== 1'b1 || IMemReqAddr !== 32'h104) begin
         errors++; $display("FAIL br_c5: got fv=%b v=%b a=%h want 0/1/104", FetchValid, IMemReqValid, IMemReqAddr);
      end
      checks++;
      IMemRespValid = 1'b1; IMemRespData = instr_of(mem_q.pop_front());
      tick(); // C6
      if (FetchValid !== 1'b1 || PCResultOut !== 32'h104 || InstructionOut !== 32'hC0DE_0100) begin
         errors++; $display("FAIL br_c6: got fv=%b pc4=%h i=%h want 1/104/c0de0100", FetchValid, PCResultOut, InstructionOut);
      end
      checks++;
   endtask

   task automatic test_ready_low();
      do_reset();
      tick(); // C1
      IMemReqReady = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         if (IMemReqValid !== 1'b1 || IMemReqAddr !== 32'h4) begin
            errors++; $display("FAIL rdy_hold_c%0d: got v=%b a=%h want 1/4", c, IMemReqValid, IMemReqAddr);
         end
         checks++;
         if (c == 2 && (FetchValid !== 1'b1 || PCResultOut !== 32'h4)) begin
            errors++; $display("FAIL rdy_out_c2: got fv=%b pc4=%h want 1/4", FetchValid, PCResultOut);
         end
         if (c == 2) checks++;
         tick();
      end
      // C5
      if (IMemReqAddr !== 32'h4) begin errors++; $display("FAIL rdy_c5: got a=%h want 4", IMemReqAddr); end
      checks++;
      IMemReqReady = 1'b1;
      tick(); // C6
      if (IMemReqValid !== 1'b1 || IMemReqAddr !== 32'h8) begin
         errors++; $display("FAIL rdy_c6: got v=%b a=%h want 1/8", IMemReqValid, IMemReqAddr);
      end
      checks++;
      tick(); // C7
      if (FetchValid !== 1'b1 || PCResultOut !== 32'h8) begin
         errors++; $display("FAIL rdy_c7: got fv=%b pc4=%h want 1/8", FetchValid, PCResultOut);
      end
      checks++;
   endtask

   task automatic test_redirect_collision();
      do_reset();
      tick(); // C1: response for 0, accept of 4 and redirect together
      BranchTaken = 1'b1; BranchTarget = 32'h200;
      tick(); // C2
      if (IMemReqValid !== 1'b1 || IMemReqAddr !== 32'h200 || FetchValid !== 1'b0) begin
         errors++; $display("FAIL col_c2: got v=%b a=%h fv=%b want 1/200/0", IMemReqValid, IMemReqAddr, FetchValid);
      end
      checks++;
      tick(); // C3
      if (FetchValid !== 1'b0 || IMemReqValid !== 1'b1 || IMemReqAddr !== 32'h204) begin
         errors++; $display("FAIL col_c3: got fv=%b v=%b a=%h want 0/1/204", FetchValid, IMemReqValid, IMemReqAddr);
      end
      checks++;
      tick(); // C4
      if (FetchValid !== 1'b1 || PCResultOut !== 32'h204 || InstructionOut !== 32'hC0DE_0200) begin
         errors++; $display("FAIL col_c4: got fv=%b pc4=%h i=%h want 1/204/c0de0200", FetchValid, PCResultOut, InstructionOut);
      end
      checks++;
   endtask

   task automatic test_wrap();
      do_reset();
      BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFF8;
      tick(); // C1
      if (IMemReqValid !== 1'b1 || IMemReqAddr !== 32'hFFFF_FFF8) begin
         errors++; $display("FAIL wrap_c1: got v=%b a=%h want 1/fffffff8", IMemReqValid, IMemReqAddr);
      end
      checks++;
      tick(); // C2
      if (IMemReqValid !== 1'b1 || IMemReqAddr !== 32'hFFFF_FFFC || FetchValid !== 1'b0) begin
         errors++; $display("FAIL wrap_c2: got v=%b a=%h fv=%b want 1/fffffffc/0", IMemReqValid, IMemReqAddr, FetchValid);
      end
      checks++;
      tick(); // C3
      if (FetchValid !== 1'b1 || PCResultOut !== 32'hFFFF_FFFC || InstructionOut !== 32'hC0DE_FFF8) begin
         errors++; $display("FAIL wrap_c3: got fv=%b pc4=%h i=%h want 1/fffffffc/c0defff8", FetchValid, PCResultOut, InstructionOut);
      end
      checks++;
      tick(); // C4
      if (FetchValid !== 1'b1 || PCResultOut !== 32'h0 || IMemReqValid !== 1'b1 || IMemReqAddr !== 32'h0) begin
         errors++; $display("FAIL wrap_c4: got fv=%b pc4=%h v=%b a=%h want 1/0/1/0", FetchValid, PCResultOut, IMemReqValid, IMemReqAddr);
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      StallIF = 1'b1;
      tick(); tick(); tick(); // C3: two entries buffered
      if (FetchValid !== 1'b1 || PCResultOut !== 32'h4) begin
         errors++; $display("FAIL mid_pre: got fv=%b pc4=%h want 1/4", FetchValid, PCResultOut);
      end
      checks++;
      #3 Reset = 1'b0;
      #1;
      if (FetchValid !== 1'b0 || InstructionOut !== 32'h0 || PCResultOut !== 32'h0 || IMemReqValid !== 1'b0) begin
         errors++; $display("FAIL mid_async: got fv=%b i=%h pc4=%h v=%b want 0/0/0/0", FetchValid, InstructionOut, PCResultOut, IMemReqValid);
      end
      checks++;
      StallIF = 1'b0; IMemRespValid = 1'b0; mem_q.delete();
      @(posedge Clock); #1;
      Reset = 1'b1;
      #1;
      if (IMemReqValid !== 1'b1 || IMemReqAddr !== 32'h0 || FetchValid !== 1'b0) begin
         errors++; $display("FAIL mid_restart: got v=%b a=%h fv=%b want 1/0/0", IMemReqValid, IMemReqAddr, FetchValid);
      end
      checks++;
      tick(); tick(); // C2
      if (FetchValid !== 1'b1 || PCResultOut !== 32'h4) begin
         errors++; $display("FAIL mid_c2: got fv=%b pc4=%h want 1/4", FetchValid, PCResultOut);
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_branch();
      test_ready_low();
      test_redirect_collision();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_instruction_fetch_stage
